// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/one_bit_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bi, bo = borrow out.
module one_bit_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   // Borrow when b exceeds a, or when a == b and a borrow comes in.
   always_comb begin
      d  = a ^ b ^ bi;
      bo = (~a & b) | (~(a ^ b) & bi);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, start/ready/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             borrow
);

   localparam int CNT_W = $clog2(WIDTH);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_chk
      $error("serial_subtractor: WIDTH out of range 2..32");
   end

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bflop_q, bflop_d;
   logic             borrow_q, borrow_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             d_s, bo_s;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   one_bit_subtractor u_bit (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .bi (bflop_q),
      .d  (d_s),
      .bo (bo_s)
   );

   // Next-state, datapath shifting and result capture.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      bflop_d  = bflop_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               bflop_d = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            res_sh_d = {d_s, res_sh_q[WIDTH-1:1]};
            bflop_d  = bo_s;
            cnt_d    = cnt_q + CNT_W'(1);
            // Last slice: publish the completed word together with the MSB borrow.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = DONE;
               diff_d   = res_sh_d;
               borrow_d = bo_s;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d    = bflop_q ^ bo_s;
`endif
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bflop_q  <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         bflop_q  <= bflop_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. It computes diff = a - b over WIDTH cycles, one bit per cycle, LSB first.
- Borrow is carried between cycles in a single flop.
- It is the inverse arithmetic counterpart of the team's one-bit full adder. It serves area-constrained datapaths that trade latency for a single bit-slice, and uses a start/ready/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start.
- borrow  output  1  unsigned borrow out of the MSB (1 iff a < b unsigned); held with diff.
- ovf  output  1  signed overflow; present only with the macro.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ready=1, done=0.
  - diff=0, borrow=0, ovf=0.
  - Shift registers, borrow flop and bit counter all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at edge k: load a_sh<=a, b_sh<=b, bflop<=0, cnt<=0, go to RUN.
  - diff and borrow are not cleared on start; they hold the previous result.
- RUN, one bit per edge:
  - d = a_sh[0]^b_sh[0]^bflop.
  - bout = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bflop).
  - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right; bflop<=bout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE.
  - RUN occupies edges k+1 .. k+WIDTH.
- DONE (entered after edge k+WIDTH):
  - done=1 for exactly one cycle; diff=res_sh, borrow=bflop (registered outputs, updated on that edge).
  - Next edge returns to IDLE.
  - Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
- ready=0 in RUN and DONE.
  - start is ignored in RUN and DONE; no queuing.
  - a and b may change freely after acceptance.
- Back-to-back operation: the earliest next accepted start is in the IDLE cycle following DONE, giving throughput of one result per WIDTH+2 cycles.
- Width rules:
  - cnt is $clog2(WIDTH) bits and compares against WIDTH-1.
  - Arithmetic is modulo 2^WIDTH; no sign extension.
- Boundaries:
  - a==b gives diff=0, borrow=0.
  - 0 - (2^WIDTH-1) gives diff=1, borrow=1.
- Reset mid-RUN aborts immediately: all state returns to reset values and no done is produced.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists.
  - On the final RUN edge, ovf <= bflop ^ bout (borrow into the MSB XOR borrow out of the MSB).
  - ovf is held with diff and reset to 0.
- Undefined: the ovf port and its flop are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - localparam MAX_WIDTH = 32.
- Sub-module one_bit_subtractor: purely combinational; inputs a, b, bi; outputs d, bo. One instance forms the bit-slice.

Test Plan:
- WIDTH=8, a=100, b=37, start pulse → done exactly 9 cycles later; diff=63, borrow=0; ready returns 1 the next cycle.
- a=8'h05, b=8'h09 → diff=8'hFC, borrow=1.
- a=8'hFF, b=8'hFF, then a=8'h00, b=8'hFF back-to-back:
  - first result diff=0, borrow=0;
  - second accepted in the IDLE cycle after DONE, giving diff=8'h01, borrow=1.
- start held high throughout, with a/b changed during RUN → only the first operands are used and exactly one done per WIDTH+2 cycles.
- rst_n low at cycle 4 of RUN, then a new start with a=10, b=3 → no stray done; diff=0 after reset; then diff=7, borrow=0.
- With SERIAL_SUB_OVF_EN:
  - 8'h80 - 8'h01 → diff=8'h7F, ovf=1, borrow=0.
  - 8'h10 - 8'h01 → ovf=0.
